mux2_rr_select: RTL and testbench

Two-channel round-robin selector that generates the `selection` input of the 2x1 multiplexer and registers the multiplexed result. It sits directly upstream of the mux's consumer: two valid/ready producers enter, one registered valid/ready stream leaves. Per-bit data steering uses the team's 2x1 mux.

---
 rtl/mux2_pkg.sv | 11 +
 rtl/MU2X1.sv | 10 +
 rtl/mux2_rr_select.sv | 84 ++++++++
 tb/tb_mux2_rr_select.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mux2_pkg.sv
// Shared types and constants for the two-channel round-robin selector.
package mux2_pkg;

  localparam int DATA_W = 8;

  typedef logic src_t;

  // Reset value of the last-grant register, so channel 0 wins the first contention.
  localparam src_t LAST_RST = 1'b1;

endpackage

// File: rtl/MU2X1.sv
// One-bit 2x1 multiplexer used for per-bit data steering.
module MU2X1 (
  input  logic [1:0] in,
  input  logic       selection,
  output logic       out
);

  assign out = in[selection];

endmodule

// File: rtl/mux2_rr_select.sv
// Two-producer round-robin arbiter feeding a one-deep registered valid/ready output.
module mux2_rr_select #(
  parameter int DATA_W = mux2_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  output logic [1:0]        in_ready,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready
);

  import mux2_pkg::*;

  src_t              last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  src_t              out_src_q, out_src_d;

  logic              load_en;
  logic              any_vld;
  src_t              grant;
  logic              xfer;
  logic [DATA_W-1:0] mux_out;

  for (genvar k = 0; k < DATA_W; k++) begin : g_mux
    MU2X1 u_mux (
      .in        ({in_data1[k], in_data0[k]}),
      .selection (sel),
      .out       (mux_out[k])
    );
  end

  // Control depends only on valids, output occupancy and last grant, never on data.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    any_vld  = |in_valid;
    grant    = (&in_valid) ? ~last_q : in_valid[1];
    sel      = rst_n ? (any_vld ? grant : last_q) : LAST_RST;
    in_ready = '0;
    if (rst_n && load_en && any_vld) in_ready[grant] = 1'b1;
    xfer     = |in_ready;
  end

  // A load takes priority over a drain, so drain-and-load keeps out_valid high.
  always_comb begin
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_data_d  = mux_out;
      out_src_d   = grant;
      out_valid_d = 1'b1;
      last_d      = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= LAST_RST;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux2_rr_select.sv
// Scoreboard bench for mux2_rr_select: directed scenarios followed by random traffic.
module tb_mux2_rr_select;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_valid;
  logic [7:0] in_data0, in_data1;
  logic [1:0] in_ready;
  logic       sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       s;
  } exp_t;
  exp_t sb[$];

  // Reference state: who was granted last and whether the output slot is full.
  int   m_last = 1;
  bit   m_full = 0;
  bit   prev_rst_low = 0;

  always #5 clk = ~clk;

  mux2_rr_select #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: decides which channel should be accepted this cycle and pushes the word.
  always @(negedge clk) begin
    int  winner;
    bit  take;
    if (prev_rst_low) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_src", {31'd0, out_src}, 32'd0);
    end
    if (!rst_n) begin
      chk("rst_in_ready", {30'd0, in_ready}, 32'd0);
      chk("rst_sel", {31'd0, sel}, 32'd1);
      m_last = 1;
      m_full = 0;
      sb.delete();
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      if (in_valid == 2'b11) winner = 1 - m_last;
      else if (in_valid == 2'b01) winner = 0;
      else if (in_valid == 2'b10) winner = 1;
      else winner = -1;
      take = (winner >= 0) && (!m_full || out_ready);
      chk("sel", {31'd0, sel}, (winner >= 0) ? winner : m_last);
      chk("in_ready", {30'd0, in_ready}, take ? (32'd1 << winner) : 32'd0);
      if (take) begin
        sb.push_back('{d: (winner == 1) ? in_data1 : in_data0, s: winner[0]});
        m_last = winner;
        m_full = 1;
      end else if (out_ready) begin
        m_full = 0;
      end
    end
    prev_rst_low = !rst_n;
  end

  // Monitor: compares the presented word with the scoreboard head, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        chk("out_data", {24'd0, out_data}, {24'd0, sb[0].d});
        chk("out_src", {31'd0, out_src}, {31'd0, sb[0].s});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input logic rn, input logic [1:0] v, input logic [7:0] a,
                     input logic [7:0] b, input logic ordy);
    rst_n     = rn;
    in_valid  = v;
    in_data0  = a;
    in_data1  = b;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 2'b11; in_data0 = 8'h00; in_data1 = 8'h00; out_ready = 1'b0;
    // Reset with both channels requesting
    repeat (3) cyc(1'b0, 2'b11, 8'hEE, 8'hDD, 1'b1);
    // Contention: expect A5,3C,A5,3C
    repeat (4) cyc(1'b1, 2'b11, 8'hA5, 8'h3C, 1'b1);
    // Lone requester on channel 1
    cyc(1'b1, 2'b10, 8'hFF, 8'h11, 1'b1);
    cyc(1'b1, 2'b10, 8'hFF, 8'h22, 1'b1);
    cyc(1'b1, 2'b10, 8'hFF, 8'h33, 1'b1);
    // Backpressure after loading 5A from channel 0
    cyc(1'b1, 2'b01, 8'h5A, 8'h00, 1'b1);
    repeat (3) cyc(1'b1, 2'b11, 8'h99, 8'h66, 1'b0);
    cyc(1'b1, 2'b11, 8'h99, 8'h66, 1'b1);
    // Drain-and-load
    cyc(1'b1, 2'b01, 8'h77, 8'h00, 1'b1);
    cyc(1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
    // Mid-stream reset with C3 held
    cyc(1'b1, 2'b01, 8'hC3, 8'h00, 1'b1);
    cyc(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
    cyc(1'b0, 2'b11, 8'h12, 8'h34, 1'b0);
    cyc(1'b1, 2'b11, 8'hAA, 8'hBB, 1'b1);
    cyc(1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) != 0),
          2'($urandom_range(0, 3)),
          8'($urandom),
          8'($urandom),
          ($urandom_range(0, 3) != 0));
    end
    repeat (3) cyc(1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
